// File: rtl/count_event_if.sv
// Bundle of the observed counter signals and the event-record stream.
// The master side is the monitor: it samples count_in/count_rst and sources
// event records. The slave side drives the counter sample and consumes records.
//
// Handshake: a record transfers on a rising clk edge where evt_valid=1 and
// evt_ready=1. While evt_valid=1 and evt_ready=0 the record fields hold steady.
// evt_ready may be asserted at any time and has no effect while evt_valid=0.
interface count_event_if #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8,
    parameter int DEPTH  = 4
) ();
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count_in;
    logic              count_rst;
    logic              evt_valid;
    logic              evt_ready;
    logic [1:0]        evt_type;
    logic [CNT_W-1:0]  evt_value;
    logic [WRAP_W-1:0] evt_wraps;
    logic              overflow;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        input  count_in,
        input  count_rst,
        input  evt_ready,
        output evt_valid,
        output evt_type,
        output evt_value,
        output evt_wraps,
        output overflow,
        output fifo_level
    );

    modport slave (
        output count_in,
        output count_rst,
        output evt_ready,
        input  evt_valid,
        input  evt_type,
        input  evt_value,
        input  evt_wraps,
        input  overflow,
        input  fifo_level
    );
endinterface

// File: rtl/count_event_monitor.sv
// Watches a free-running counter and its reset. Every cycle-to-cycle step is
// classified as WRAP (MAX->0), CLEAR (counter reset took a nonzero counter to
// zero) or SKIP (any value other than previous+1, including a held value).
// Each event becomes a {type, value, wrap total} record in a small
// first-word-fall-through FIFO drained over the valid/ready stream in ev.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module count_event_monitor #(
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    count_event_if.master ev
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        EVT_WRAP  = 2'd0,
        EVT_CLEAR = 2'd1,
        EVT_SKIP  = 2'd2
    } evt_kind_t;

    typedef struct packed {
        evt_kind_t         kind;
        logic [CNT_W-1:0]  value;
        logic [WRAP_W-1:0] wraps;
    } evt_rec_t;

    // Previous-cycle sample of the counter and its reset.
    logic [CNT_W-1:0]  prev_cnt;
    logic              prev_rst;
    logic              prev_valid;

    // Saturating number of wraps seen since rst.
    logic [WRAP_W-1:0] wrap_total;
    logic [WRAP_W-1:0] wrap_next;

    // Event FIFO storage and bookkeeping.
    evt_rec_t          mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  level;
    logic              overflow_q;

    // Classification results for the edge about to happen.
    logic              evt_det;
    evt_kind_t         evt_kind;
    logic [CNT_W-1:0]  prev_succ;
    evt_rec_t          new_rec;
    evt_rec_t          head;

    // FIFO control.
    logic              fifo_empty;
    logic              fifo_full;
    logic              do_pop;
    logic              do_push;
    logic              do_drop;

    assign prev_succ = prev_cnt + CNT_ONE;

    // Classify the step from prev to the current sample; first matching rule wins.
    always_comb begin
        evt_det   = 1'b0;
        evt_kind  = EVT_WRAP;
        wrap_next = wrap_total;
        if (prev_valid) begin
            if (prev_rst) begin
                // A counter reset that found the counter already at zero is silent,
                // and no other rule is consulted for this step.
                if (prev_cnt != '0) begin
                    evt_det  = 1'b1;
                    evt_kind = EVT_CLEAR;
                end
            end else if ((prev_cnt == CNT_MAX) && (ev.count_in == '0)) begin
                evt_det  = 1'b1;
                evt_kind = EVT_WRAP;
                if (wrap_total != WRAP_MAX) begin
                    wrap_next = wrap_total + WRAP_ONE;
                end
            end else if (ev.count_in != prev_succ) begin
                evt_det  = 1'b1;
                evt_kind = EVT_SKIP;
            end
        end
    end

    // Record carries the wrap total as it stands after this edge's update.
    always_comb begin
        new_rec       = '0;
        new_rec.kind  = evt_kind;
        new_rec.value = ev.count_in;
        new_rec.wraps = wrap_next;
    end

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_FULL);

    // A pop on a full FIFO frees the slot the new record needs in the same cycle.
    assign do_pop  = !fifo_empty && ev.evt_ready;
    assign do_push = evt_det && (!fifo_full || do_pop);
    assign do_drop = evt_det && fifo_full && !do_pop;

    // Sample tracking and wrap total; rst overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cnt   <= '0;
            prev_rst   <= 1'b0;
            prev_valid <= 1'b0;
            wrap_total <= '0;
        end else begin
            prev_cnt   <= ev.count_in;
            prev_rst   <= ev.count_rst;
            prev_valid <= 1'b1;
            wrap_total <= wrap_next;
        end
    end

    // FIFO storage; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    // FIFO pointers, level and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (do_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head record is forced to zero while empty so outputs are clean after rst.
    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head = mem[rd_ptr];
        end
    end

    assign ev.evt_valid  = !fifo_empty;
    assign ev.evt_type   = head.kind;
    assign ev.evt_value  = head.value;
    assign ev.evt_wraps  = head.wraps;
    assign ev.overflow   = overflow_q;
    assign ev.fifo_level = level;

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: reset check, a table of directed vectors,
// hand-written multi-cycle corner sequences and a randomized run, all checked
// against a queue-based model of the event stream.
module tb_count_event_monitor;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 4;
    localparam int WRAP_W = 8;
    localparam int LVL_W  = 3;
    localparam int REC_W  = 2 + CNT_W + WRAP_W;
    localparam int CNT_MOD  = 1 << CNT_W;
    localparam int WRAP_SAT = (1 << WRAP_W) - 1;

    localparam logic [1:0] T_WRAP  = 2'd0;
    localparam logic [1:0] T_CLEAR = 2'd1;
    localparam logic [1:0] T_SKIP  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    count_event_if #(.CNT_W(CNT_W), .WRAP_W(WRAP_W), .DEPTH(DEPTH)) ev ();

    count_event_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .ev  (ev)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [REC_W-1:0] exp_q[$];
    logic [CNT_W:0]   hist[$];
    int               m_wraps;
    bit               m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model over one clock edge, using the spec rules directly.
    task automatic model_step(input logic [CNT_W-1:0] cnt, input logic crst, input logic rdy);
        bit         found;
        logic [1:0] ty;
        int         p_cnt;
        bit         p_rst;
        logic [CNT_W:0] last;
        found = 0;
        ty = T_WRAP;
        if (rst) begin
            exp_q.delete();
            hist.delete();
            m_wraps = 0;
            m_ovf = 0;
            return;
        end
        if (hist.size() > 0) begin
            last  = hist[hist.size()-1];
            p_rst = last[CNT_W];
            p_cnt = int'(last[CNT_W-1:0]);
            if (p_rst) begin
                if (p_cnt != 0) begin found = 1; ty = T_CLEAR; end
            end else if (p_cnt == CNT_MOD - 1 && int'(cnt) == 0) begin
                found = 1; ty = T_WRAP;
                m_wraps = (m_wraps < WRAP_SAT) ? m_wraps + 1 : WRAP_SAT;
            end else if (int'(cnt) != (p_cnt + 1) % CNT_MOD) begin
                found = 1; ty = T_SKIP;
            end
        end
        if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
        if (found) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({ty, cnt, m_wraps[WRAP_W-1:0]});
            else m_ovf = 1;
        end
        hist.push_back({crst, cnt});
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic model_compare();
        logic [REC_W-1:0] h;
        check("m.valid", ev.evt_valid, exp_q.size() != 0);
        check("m.level", ev.fifo_level, exp_q.size());
        check("m.overflow", ev.overflow, m_ovf);
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("m.type",  ev.evt_type,  h[REC_W-1 -: 2]);
            check("m.value", ev.evt_value, h[WRAP_W +: CNT_W]);
            check("m.wraps", ev.evt_wraps, h[WRAP_W-1:0]);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs for one cycle, step the model, compare #1 after the edge.
    task automatic cycle(input logic [CNT_W-1:0] cnt, input logic crst, input logic rdy);
        ev.count_in  = cnt;
        ev.count_rst = crst;
        ev.evt_ready = rdy;
        @(negedge clk);
        model_step(cnt, crst, rdy);
        @(posedge clk);
        #1;
        model_compare();
    endtask

    task automatic expect_state(input string name, input logic v, input logic [1:0] t,
                                input logic [CNT_W-1:0] val, input logic [WRAP_W-1:0] w,
                                input logic [LVL_W-1:0] lvl, input logic ovf);
        check({name, ".valid"}, ev.evt_valid, v);
        check({name, ".level"}, ev.fifo_level, lvl);
        check({name, ".overflow"}, ev.overflow, ovf);
        if (v) begin
            check({name, ".type"},  ev.evt_type,  t);
            check({name, ".value"}, ev.evt_value, val);
            check({name, ".wraps"}, ev.evt_wraps, w);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [CNT_W-1:0]  cnt;
        logic              crst;
        logic              rdy;
        logic              e_valid;
        logic [1:0]        e_type;
        logic [CNT_W-1:0]  e_value;
        logic [WRAP_W-1:0] e_wraps;
        logic [LVL_W-1:0]  e_level;
        logic              e_ovf;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int cur;
        int bias;
        logic crst;

        // Expected values describe the state right after each row's edge.
        tbl[0]  = '{4'd2,  1'b0, 1'b0, 1'b0, T_WRAP,  4'd0, 8'd0, 3'd0, 1'b0};
        tbl[1]  = '{4'd3,  1'b0, 1'b0, 1'b0, T_WRAP,  4'd0, 8'd0, 3'd0, 1'b0};
        tbl[2]  = '{4'd7,  1'b0, 1'b0, 1'b1, T_SKIP,  4'd7, 8'd0, 3'd1, 1'b0};
        tbl[3]  = '{4'd7,  1'b0, 1'b0, 1'b1, T_SKIP,  4'd7, 8'd0, 3'd2, 1'b0};
        tbl[4]  = '{4'd8,  1'b0, 1'b0, 1'b1, T_SKIP,  4'd7, 8'd0, 3'd2, 1'b0};
        tbl[5]  = '{4'd9,  1'b0, 1'b1, 1'b1, T_SKIP,  4'd7, 8'd0, 3'd1, 1'b0};
        tbl[6]  = '{4'd10, 1'b0, 1'b1, 1'b0, T_WRAP,  4'd0, 8'd0, 3'd0, 1'b0};
        tbl[7]  = '{4'd11, 1'b0, 1'b1, 1'b0, T_WRAP,  4'd0, 8'd0, 3'd0, 1'b0};
        tbl[8]  = '{4'd12, 1'b1, 1'b0, 1'b0, T_WRAP,  4'd0, 8'd0, 3'd0, 1'b0};
        tbl[9]  = '{4'd0,  1'b1, 1'b0, 1'b1, T_CLEAR, 4'd0, 8'd0, 3'd1, 1'b0};
        tbl[10] = '{4'd0,  1'b0, 1'b0, 1'b1, T_CLEAR, 4'd0, 8'd0, 3'd1, 1'b0};
        tbl[11] = '{4'd1,  1'b0, 1'b1, 1'b0, T_WRAP,  4'd0, 8'd0, 3'd0, 1'b0};
        tbl[12] = '{4'd2,  1'b0, 1'b0, 1'b0, T_WRAP,  4'd0, 8'd0, 3'd0, 1'b0};

        rst = 1'b1;
        ev.count_in  = '0;
        ev.count_rst = 1'b0;
        ev.evt_ready = 1'b0;

        // Reset values, including the zeroed record fields.
        do_reset();
        check("rst.valid", ev.evt_valid, 1'b0);
        check("rst.type", ev.evt_type, 2'd0);
        check("rst.value", ev.evt_value, 4'd0);
        check("rst.wraps", ev.evt_wraps, 8'd0);
        check("rst.overflow", ev.overflow, 1'b0);
        check("rst.level", ev.fifo_level, 3'd0);

        // Table: SKIP on jump and hold, CLEAR on counter reset, no SKIP on 12->0.
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].cnt, tbl[i].crst, tbl[i].rdy);
            expect_state($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_type,
                         tbl[i].e_value, tbl[i].e_wraps, tbl[i].e_level, tbl[i].e_ovf);
        end

        // Free run from 0 with ready high: one WRAP, valid for exactly one cycle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(CNT_W'(i % CNT_MOD), 1'b0, 1'b1);
            check($sformatf("wrap.valid%0d", i), ev.evt_valid, i == 16);
            if (i == 16) expect_state("wrap.rec", 1'b1, T_WRAP, 4'd0, 8'd1, 3'd1, 1'b0);
        end

        // Six wraps with ready low: fill, overflow, drain 1..4, next wrap reports 7.
        do_reset();
        for (int i = 0; i <= 96; i++) cycle(CNT_W'(i % CNT_MOD), 1'b0, 1'b0);
        expect_state("ovf.full", 1'b1, T_WRAP, 4'd0, 8'd1, 3'd4, 1'b1);
        for (int i = 97; i <= 100; i++) begin
            cycle(CNT_W'(i % CNT_MOD), 1'b0, 1'b1);
            if (i < 100)
                expect_state($sformatf("ovf.drain%0d", i), 1'b1, T_WRAP, 4'd0,
                             WRAP_W'(i - 95), LVL_W'(100 - i), 1'b1);
            else
                expect_state("ovf.empty", 1'b0, T_WRAP, 4'd0, 8'd0, 3'd0, 1'b1);
        end
        for (int i = 101; i <= 112; i++) cycle(CNT_W'(i % CNT_MOD), 1'b0, 1'b0);
        expect_state("ovf.wrap7", 1'b1, T_WRAP, 4'd0, 8'd7, 3'd1, 1'b1);

        // Full FIFO, ready high and a new event on the same edge.
        do_reset();
        for (int i = 0; i <= 64; i++) cycle(CNT_W'(i % CNT_MOD), 1'b0, 1'b0);
        expect_state("full.fill", 1'b1, T_WRAP, 4'd0, 8'd1, 3'd4, 1'b0);
        cycle(4'd1, 1'b0, 1'b0);
        cycle(4'd5, 1'b0, 1'b1);
        expect_state("full.pushpop", 1'b1, T_WRAP, 4'd0, 8'd2, 3'd4, 1'b0);
        cycle(4'd6, 1'b0, 1'b1);
        expect_state("full.d1", 1'b1, T_WRAP, 4'd0, 8'd3, 3'd3, 1'b0);
        cycle(4'd7, 1'b0, 1'b1);
        expect_state("full.d2", 1'b1, T_WRAP, 4'd0, 8'd4, 3'd2, 1'b0);
        cycle(4'd8, 1'b0, 1'b1);
        expect_state("full.d3", 1'b1, T_SKIP, 4'd5, 8'd4, 3'd1, 1'b0);
        cycle(4'd9, 1'b0, 1'b1);
        expect_state("full.d4", 1'b0, T_WRAP, 4'd0, 8'd0, 3'd0, 1'b0);

        // rst with 3 records queued and overflow set; no event on release edge.
        do_reset();
        cycle(4'd0, 1'b0, 1'b0);
        cycle(4'd5, 1'b0, 1'b0);
        cycle(4'd9, 1'b0, 1'b0);
        cycle(4'd2, 1'b0, 1'b0);
        cycle(4'd7, 1'b0, 1'b0);
        cycle(4'd1, 1'b0, 1'b0);
        cycle(4'd2, 1'b0, 1'b1);
        expect_state("mid.pre", 1'b1, T_SKIP, 4'd9, 8'd0, 3'd3, 1'b1);
        rst = 1'b1;
        cycle(4'd3, 1'b0, 1'b1);
        expect_state("mid.rst", 1'b0, T_WRAP, 4'd0, 8'd0, 3'd0, 1'b0);
        rst = 1'b0;
        cycle(4'd12, 1'b0, 1'b0);
        expect_state("mid.rel", 1'b0, T_WRAP, 4'd0, 8'd0, 3'd0, 1'b0);
        cycle(4'd13, 1'b0, 1'b0);
        expect_state("mid.next", 1'b0, T_WRAP, 4'd0, 8'd0, 3'd0, 1'b0);

        // Saturation of the wrap total: alternate 15/0 so every other step wraps.
        do_reset();
        cycle(4'd15, 1'b0, 1'b1);
        for (int k = 0; k < 260; k++) begin
            cycle(4'd0, 1'b0, 1'b1);
            cycle(4'd15, 1'b0, 1'b1);
        end
        expect_state("sat", 1'b1, T_SKIP, 4'd15, 8'd255, 3'd1, 1'b0);

        // Randomized counter behaviour against the model.
        do_reset();
        cur = 0;
        bias = 50;
        for (int n = 0; n < 2000; n++) begin
            if (n % 50 == 0) bias = (($urandom_range(0, 2)) * 40) + 10;
            rst = ($urandom_range(0, 199) == 0);
            crst = ($urandom_range(0, 14) == 0);
            cycle(CNT_W'(cur), crst, $urandom_range(0, 99) < bias);
            if (crst) cur = 0;
            else begin
                case ($urandom_range(0, 9))
                    0:       cur = $urandom_range(0, CNT_MOD - 1);
                    1:       cur = cur;
                    default: cur = (cur + 1) % CNT_MOD;
                endcase
            end
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
